vec_variance: RTL and testbench
===============================

VEC_VARIANCE -- requirements
Module: vec_variance

Interface
REQ-001 Parameter ARR_WIDTH, default 4: elements per vector; SHALL be a power of two, 2 or more.
REQ-002 Parameter FXP_N, default 16: signed fixed-point word width.
REQ-003 Parameter FXP_R, default 8: fractional bits, 0 < FXP_R < FXP_N.
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 in_valid  in  1  input_arr and mean_in are valid.
REQ-007 in_ready  out  1  block can accept a vector.
REQ-008 input_arr  in  ARR_WIDTH x FXP_N  signed vector, the same vector that was fed to the upstream mean stage.
REQ-009 mean_in  in  FXP_N  signed mean of input_arr, from the upstream mean stage.
REQ-010 out_valid  out  1  centered_arr and var_out are valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 centered_arr  out  ARR_WIDTH x FXP_N  signed, element i = input_arr[i] - mean_in.
REQ-013 var_out  out  FXP_N  signed population variance of input_arr.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-015 IDLE:
- in_ready=1, out_valid=0.
- When in_valid=1, latch input_arr and mean_in, clear the accumulator, set idx=0, go to ACCUM.
REQ-016 ACCUM processes one element per cycle, with in_ready=0 and out_valid=0:
- d = input_arr[idx] - mean_in, computed in FXP_N+1 bits.
- centered_arr[idx] <= d narrowed to FXP_N bits.
- acc += (d*d) >>> FXP_R, with acc at least 2*FXP_N+2+log2(ARR_WIDTH) bits, so acc never overflows.
REQ-017 When idx = ARR_WIDTH-1, the FSM SHALL register var_out = acc_final >>> log2(ARR_WIDTH), narrowed to FXP_N bits, and go to DONE.
REQ-018 DONE:
- out_valid=1.
- centered_arr and var_out held stable until out_ready=1.
- The handshake edge returns the FSM to IDLE.
- in_ready=0 throughout DONE; there is no back-to-back accept.
REQ-019 Latency: out_valid SHALL rise exactly ARR_WIDTH cycles after the accept edge; throughput is one vector per ARR_WIDTH+2 cycles minimum.
REQ-020 Input changes outside the accept edge SHALL NOT affect the result.
REQ-021 out_ready while out_valid=0 SHALL be ignored.
REQ-022 Narrowing SHALL follow the Configuration section.
REQ-023 var_out SHALL never be negative when saturation is enabled.

Reset
REQ-024 While reset_n=0 at a rising edge, all of the following SHALL hold:
- FSM goes to IDLE.
- idx=0, acc=0.
- centered_arr=0, var_out=0, out_valid=0.
- in_ready=0 during the reset cycle, 1 from the first cycle after release.
REQ-025 Reset during ACCUM or DONE SHALL abort the transaction with no output handshake; the next accepted vector SHALL compute correctly.

Configuration
REQ-026 The macro is VEC_VARIANCE_SATURATE_EN.
REQ-027 With VEC_VARIANCE_SATURATE_EN defined:
- Narrowing of centered_arr saturates to [-2^(FXP_N-1), 2^(FXP_N-1)-1].
- Narrowing of var_out saturates to 2^(FXP_N-1)-1.
REQ-028 Without VEC_VARIANCE_SATURATE_EN, narrowing keeps the low FXP_N bits (two's-complement wrap).

Verification
All scenarios use ARR_WIDTH=4, FXP_N=16, FXP_R=8.
REQ-029 Ramp: {1.0,2.0,3.0,4.0}, mean 2.5 -> centered {0xFE80,0xFF80,0x0080,0x0180}; var_out=0x0140 (1.25); out_valid 4 cycles after accept.
REQ-030 Constant: all 1.0, mean 1.0 -> centered all 0; var_out=0x0000.
REQ-031 Fractional: {0.25,0.5,0.75,1.0}, mean 0.625 -> var_out=0x0014 (0.078125).
REQ-032 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; IDLE the cycle after out_ready=1.
REQ-033 Overflow: {100,-100,100,-100}, mean 0 -> var_out=0x7FFF with macro, 0x1000 without; centered {0x6400,0x9C00,0x6400,0x9C00} in both builds.
REQ-034 Reset at the second ACCUM cycle -> next cycle out_valid=0, in_ready=1, outputs 0; a following ramp vector yields 0x0140.

Source files
------------

// File: rtl/vec_variance.sv
// rtl/vec_variance.sv - centers a vector on its mean and computes population variance
// Optional feature: define VEC_VARIANCE_SATURATE_EN to saturate instead of wrap when narrowing.
module vec_variance #(
    parameter int ARR_WIDTH = 4,
    parameter int FXP_N     = 16,
    parameter int FXP_R     = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ARR_WIDTH*FXP_N-1:0]   input_arr,
    input  logic [FXP_N-1:0]             mean_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ARR_WIDTH*FXP_N-1:0]   centered_arr,
    output logic [FXP_N-1:0]             var_out
);

    localparam int LOG2_W = $clog2(ARR_WIDTH);
    localparam int IDX_W  = (LOG2_W > 0) ? LOG2_W : 1;
    localparam int PROD_W = 2*FXP_N + 2;
    localparam int ACC_W  = PROD_W + LOG2_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                         r_state;
    logic [IDX_W-1:0]               r_idx;
    logic signed [ACC_W-1:0]        r_acc;
    logic [ARR_WIDTH*FXP_N-1:0]     r_arr;
    logic [FXP_N-1:0]               r_mean;
    logic [ARR_WIDTH*FXP_N-1:0]     r_centered;
    logic [FXP_N-1:0]               r_var;
    logic                           r_out_valid;
    logic                           r_in_ready;

    logic [FXP_N-1:0]               w_elem;
    logic signed [FXP_N:0]          w_diff;
    logic signed [PROD_W-1:0]       w_diff_ext;
    logic signed [PROD_W-1:0]       w_sq;
    logic signed [PROD_W-1:0]       w_term;
    logic signed [ACC_W-1:0]        w_acc_next;
    logic signed [ACC_W-1:0]        w_var_full;
    logic [FXP_N-1:0]               w_diff_nar;
    logic [FXP_N-1:0]               w_var_nar;

    assign w_elem     = r_arr[int'(r_idx)*FXP_N +: FXP_N];
    assign w_diff     = signed'({w_elem[FXP_N-1], w_elem}) - signed'({r_mean[FXP_N-1], r_mean});
    assign w_diff_ext = signed'({{(PROD_W-FXP_N-1){w_diff[FXP_N]}}, w_diff});
    assign w_sq       = w_diff_ext * w_diff_ext;
    assign w_term     = w_sq >>> FXP_R;
    // The square is never negative, so zero-extension into the accumulator is exact.
    assign w_acc_next = r_acc + signed'({{LOG2_W{1'b0}}, w_term});
    assign w_var_full = w_acc_next >>> LOG2_W;

`ifdef VEC_VARIANCE_SATURATE_EN
    always_comb begin
        w_diff_nar = w_diff[FXP_N-1:0];
        if (w_diff[FXP_N] != w_diff[FXP_N-1]) begin
            w_diff_nar = w_diff[FXP_N] ? {1'b1, {(FXP_N-1){1'b0}}} : {1'b0, {(FXP_N-1){1'b1}}};
        end
    end

    always_comb begin
        w_var_nar = w_var_full[FXP_N-1:0];
        if (w_var_full[ACC_W-1]) begin
            w_var_nar = '0;
        end else if (|w_var_full[ACC_W-1:FXP_N-1]) begin
            w_var_nar = {1'b0, {(FXP_N-1){1'b1}}};
        end
    end
`else
    assign w_diff_nar = w_diff[FXP_N-1:0];
    assign w_var_nar  = w_var_full[FXP_N-1:0];
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_arr       <= '0;
            r_mean      <= '0;
            r_centered  <= '0;
            r_var       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_arr      <= input_arr;
                        r_mean     <= mean_in;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_centered[int'(r_idx)*FXP_N +: FXP_N] <= w_diff_nar;
                    r_acc <= w_acc_next;
                    if (r_idx == IDX_W'(ARR_WIDTH-1)) begin
                        r_var       <= w_var_nar;
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Gating with reset_n keeps in_ready low during the reset cycle itself.
    assign in_ready     = r_in_ready & reset_n;
    assign out_valid    = r_out_valid;
    assign centered_arr = r_centered;
    assign var_out      = r_var;

endmodule

// File: tb/tb_vec_variance.sv
// tb/tb_vec_variance.sv - directed self-checking bench for vec_variance
module tb_vec_variance;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] input_arr;
    logic [15:0] mean_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] centered_arr;
    logic [15:0] var_out;

    int n_cmp;
    int n_err;

    vec_variance #(
        .ARR_WIDTH (4),
        .FXP_N     (16),
        .FXP_R     (8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .input_arr    (input_arr),
        .mean_in      (mean_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .centered_arr (centered_arr),
        .var_out      (var_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_vec(input string name, input logic [63:0] arr, input logic [15:0] mean,
                           input logic [63:0] exp_c, input logic [15:0] exp_v,
                           input int hold, input bit early);
        int lat;
        input_arr = arr;
        mean_in   = mean;
        in_valid  = 1'b1;
        out_ready = early;
        chk({name, "_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid  = 1'b0;
        input_arr = 64'hDEAD_BEEF_0BAD_F00D;
        mean_in   = 16'h1234;
        chk({name, "_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_centered"}, centered_arr, exp_c);
        chk({name, "_var"}, 64'(var_out), 64'(exp_v));
        for (int k = 0; k < hold; k++) begin
            in_valid  = 1'b1;
            input_arr = 64'h0100_0100_0100_0100;
            @(posedge clock); #1;
            chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({name, "_hold_ready"}, 64'(in_ready), 64'd0);
            chk({name, "_hold_var"}, 64'(var_out), 64'(exp_v));
            chk({name, "_hold_centered"}, centered_arr, exp_c);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({name, "_post_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_post_ready"}, 64'(in_ready), 64'd1);
    endtask

    logic [15:0] exp_ovf_var;

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef VEC_VARIANCE_SATURATE_EN
        exp_ovf_var = 16'h7FFF;
`else
        exp_ovf_var = 16'h1000;
`endif
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input_arr = '0;
        mean_in   = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_var", 64'(var_out), 64'd0);
        chk("rst_centered", centered_arr, 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        run_vec("ramp", 64'h0400_0300_0200_0100, 16'h0280,
                64'h0180_0080_FF80_FE80, 16'h0140, 0, 1'b0);
        run_vec("const", 64'h0100_0100_0100_0100, 16'h0100,
                64'h0, 16'h0000, 0, 1'b1);
        run_vec("frac", 64'h0100_00C0_0080_0040, 16'h00A0,
                64'h0060_0020_FFE0_FFA0, 16'h0014, 0, 1'b0);
        run_vec("bp", 64'h0400_0300_0200_0100, 16'h0280,
                64'h0180_0080_FF80_FE80, 16'h0140, 5, 1'b0);
        run_vec("ovf", 64'h9C00_6400_9C00_6400, 16'h0000,
                64'h9C00_6400_9C00_6400, exp_ovf_var, 0, 1'b0);

        input_arr = 64'h0400_0300_0200_0100;
        mean_in   = 16'h0280;
        in_valid  = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("abort_rst_ready", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_var", 64'(var_out), 64'd0);
        chk("abort_centered", centered_arr, 64'd0);
        run_vec("after_abort", 64'h0400_0300_0200_0100, 16'h0280,
                64'h0180_0080_FF80_FE80, 16'h0140, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
